shot_sequencer: RTL and testbench
=================================

# shot_sequencer

Run controller for the qubit readout chain. Once armed, it forwards exactly num_data_pts external triggers to the timing block, one shot at a time. It captures each integrated I/Q result, presents it downstream on a valid/ready handshake, and holds the configuration locked for the whole run. It sits between the external trigger / config logic and the timing → sampler → multiplier → integrator pipeline.

## Interface
Parameters:
- SHOT_W, 16, width of shot count and result index
- TO_W, 16, width of timeout counter

Ports:
- clk100  in  1  system clock
- reset  in  1  asynchronous, active-low
- arm  in  1  one-cycle start-of-run request
- abort  in  1  terminate run immediately
- num_data_pts  in  SHOT_W  shots per run; sampled on accepted arm
- timeout_cycles  in  TO_W  maximum cycles from trigger_out to iq_valid; 0 disables the timeout
- trigger_in  in  1  external trigger, one-cycle pulse
- trigger_out  out  1  gated trigger to the timing block, one-cycle pulse
- iq_valid  in  1  integrator result strobe
- i_val, q_val  in  32  integrator totals, signed
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts result
- res_i, res_q  out  32  captured result, signed
- res_idx  out  SHOT_W  shot index of the result, 0-based
- busy  out  1  state ≠ IDLE
- cfg_lock  out  1  equals busy; config writes are held off while high
- done  out  1  one-cycle pulse at normal run end
- aborted  out  1  one-cycle pulse when a run ends by abort or timeout
- err_drop  out  1  sticky: trigger_in or iq_valid arrived outside its accepting state
- err_timeout  out  1  sticky: a shot timed out
- sum_i, sum_q  out  48  run accumulators (see Configuration)

## Operation
- States: IDLE, ARMED, ACQ, HOLD.
- IDLE:
  - arm with num_data_pts > 0 latches the count, clears shot_idx, err_drop, err_timeout and the accumulators, then goes to ARMED.
  - arm with num_data_pts = 0 pulses done the next cycle, clears the sticky errors, and stays in IDLE.
- ARMED: trigger_in pulses trigger_out, clears the timeout counter, and goes to ACQ.
- ACQ:
  - iq_valid captures i_val/q_val/shot_idx into the result register, sets res_valid, and goes to HOLD.
  - Otherwise the timeout counter increments. Reaching timeout_cycles (when non-zero) sets err_timeout, pulses aborted, and goes to IDLE.
- HOLD:
  - res_valid && res_ready clears res_valid.
  - If shot_idx = latched count − 1, pulse done and go to IDLE.
  - Otherwise increment shot_idx and go to ARMED.
- Backpressure: no trigger is forwarded while a result is unconsumed. There is one result register and no FIFO.
- Dropped events set err_drop and have no other effect:
  - trigger_in in IDLE, ACQ or HOLD
  - iq_valid outside ACQ
- abort in any non-IDLE state:
  - next state IDLE, res_valid cleared, aborted pulsed, done not pulsed
  - abort in IDLE is ignored
- Simultaneous events:
  - abort beats arm, iq_valid, trigger_in and timeout.
  - iq_valid beats timeout in the same cycle.
  - arm while busy is ignored and sets no flag.
- Sticky errors hold until the next accepted arm or reset.

## Timing
- Reset values:
  - state IDLE
  - all outputs 0, including res_i/res_q/res_idx/sums
- All outputs are registered.
- trigger_in at cycle t (ARMED) → trigger_out high at t+1 only.
- iq_valid at t (ACQ) → res_valid/res_i/res_q/res_idx valid from t+1.
- Result handshake:
  - Result data is stable while res_valid && !res_ready.
  - The handshake completes on the cycle both are high.
  - The next trigger can be forwarded from the cycle after the handshake.
- done/aborted pulse at the cycle after the terminating event.
- busy/cfg_lock:
  - rise the cycle after the accepted arm
  - fall together with done/aborted
- Timeout: err_timeout is set exactly timeout_cycles cycles after trigger_out if no iq_valid has arrived.

## Configuration
- SHOT_SEQ_ACCUM_EN defined:
  - Each captured result is sign-extended and added to sum_i/sum_q on the capture cycle.
  - Sums are cleared on accepted arm and are final when done pulses.
  - Sums hold their value after abort.
- SHOT_SEQ_ACCUM_EN undefined: sum_i/sum_q are tied to 0 and no accumulator logic is built.

## Structure
- Package shot_seq_pkg:
  - state enum shot_state_t {IDLE, ARMED, ACQ, HOLD}
  - SHOT_W/TO_W defaults
  - ACC_W = 48
- One sub-module, shot_seq_out_reg: a single-entry valid/ready result register carrying data, index and the optional accumulators. The FSM and counters stay in the top.

## Test plan
- Nominal run: num_data_pts=3, timeout_cycles=0, res_ready=1, three triggers each answered with iq_valid (i=10·k, q=−k) → three results with idx 0,1,2, done once, busy low after, sum_i=30 and sum_q=−3 with SHOT_SEQ_ACCUM_EN.
- Backpressure and drops: res_ready=0 for 20 cycles after shot 0, with trigger_in pulsed during the stall → no trigger_out, err_drop=1, result stable. After res_ready rises, the next trigger is forwarded.
- Timeout: timeout_cycles=5, no iq_valid → err_timeout at 5 cycles after trigger_out, aborted pulse, IDLE, no done.
- Abort priority: abort on the same cycle as iq_valid in ACQ → IDLE, res_valid stays 0, aborted=1. A following arm clears err flags and a full run completes.
- Zero-count run: num_data_pts=0, arm → done pulse next cycle, busy never high, no trigger_out.
- Async reset mid-run: reset low during HOLD → all outputs 0 immediately, state IDLE after release.

Source files
------------

// File: rtl/shot_seq_pkg.sv
// shot_seq_pkg: shared types and constants for the shot sequencer slice.
//   shot_state_t : run state (IDLE, ARMED, ACQ, HOLD)
//   DATA_W       : integrator result width (signed I/Q)
//   SHOT_W_DEF   : default width of shot count / result index
//   TO_W_DEF     : default width of the per-shot timeout counter
//   ACC_W        : run accumulator width
//   sext_acc()   : sign-extend one result to accumulator width
package shot_seq_pkg;

    localparam int DATA_W     = 32;
    localparam int SHOT_W_DEF = 16;
    localparam int TO_W_DEF   = 16;
    localparam int ACC_W      = 48;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        ACQ   = 2'd2,
        HOLD  = 2'd3
    } shot_state_t;

    function automatic logic signed [ACC_W-1:0] sext_acc(input logic signed [DATA_W-1:0] v);
        return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
    endfunction

endpackage

// File: rtl/shot_seq_if.sv
// shot_seq_if: result stream from the shot sequencer to its consumer.
//   res_valid : result available (driven by master)
//   res_ready : consumer accepts result (driven by slave)
//   res_i/q   : captured signed I/Q totals (driven by master)
//   res_idx   : 0-based shot index of the result (driven by master)
// Modports: master = sequencer side, slave = consumer side.
interface shot_seq_if #(
    parameter int SHOT_W = 16
);
    import shot_seq_pkg::*;

    logic                     res_valid;
    logic                     res_ready;
    logic signed [DATA_W-1:0] res_i;
    logic signed [DATA_W-1:0] res_q;
    logic [SHOT_W-1:0]        res_idx;

    modport master (
        output res_valid,
        output res_i,
        output res_q,
        output res_idx,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_i,
        input  res_q,
        input  res_idx,
        output res_ready
    );

endinterface

// File: rtl/shot_seq_out_reg.sv
// shot_seq_out_reg: single-entry valid/ready result register with optional
// run accumulators.
//   clk100, reset   : clock, asynchronous active-low reset
//   load_p0         : capture i_p0/q_p0/idx_p0 and raise res_valid
//   clear_p0        : drop any pending result (abort)
//   acc_clr_p0      : zero the accumulators (accepted arm)
//   i_p0, q_p0      : signed integrator totals to capture
//   idx_p0          : shot index to capture
//   res             : result stream (master side)
//   sum_i, sum_q    : run accumulators
// Build option: SHOT_SEQ_ACCUM_EN builds the accumulators; otherwise the
// sums are constant zero.
module shot_seq_out_reg
    import shot_seq_pkg::*;
#(
    parameter int SHOT_W = SHOT_W_DEF
) (
    input  logic                     clk100,
    input  logic                     reset,
    input  logic                     load_p0,
    input  logic                     clear_p0,
    input  logic                     acc_clr_p0,
    input  logic signed [DATA_W-1:0] i_p0,
    input  logic signed [DATA_W-1:0] q_p0,
    input  logic [SHOT_W-1:0]        idx_p0,
    shot_seq_if.master               res,
    output logic signed [ACC_W-1:0]  sum_i,
    output logic signed [ACC_W-1:0]  sum_q
);

    // capture stage -> registered result outputs
    always_ff @(posedge clk100 or negedge reset) begin
        if (!reset) begin
            res.res_valid <= 1'b0;
            res.res_i     <= '0;
            res.res_q     <= '0;
            res.res_idx   <= '0;
        end else begin
            if (clear_p0)
                res.res_valid <= 1'b0;
            else if (load_p0)
                res.res_valid <= 1'b1;
            else if (res.res_valid && res.res_ready)
                res.res_valid <= 1'b0;

            // Data only moves on load, so it is stable while the consumer stalls.
            if (load_p0) begin
                res.res_i   <= i_p0;
                res.res_q   <= q_p0;
                res.res_idx <= idx_p0;
            end
        end
    end

`ifdef SHOT_SEQ_ACCUM_EN
    // capture stage -> accumulators (no clear on abort, sums hold)
    always_ff @(posedge clk100 or negedge reset) begin
        if (!reset) begin
            sum_i <= '0;
            sum_q <= '0;
        end else if (acc_clr_p0) begin
            sum_i <= '0;
            sum_q <= '0;
        end else if (load_p0) begin
            sum_i <= sum_i + sext_acc(i_p0);
            sum_q <= sum_q + sext_acc(q_p0);
        end
    end
`else
    logic unused_acc_clr;
    assign unused_acc_clr = acc_clr_p0;
    assign sum_i = '0;
    assign sum_q = '0;
`endif

endmodule

// File: rtl/shot_sequencer.sv
// shot_sequencer: run controller for the qubit readout chain. Once armed it
// forwards exactly num_data_pts triggers, one shot at a time, captures each
// I/Q result and hands it downstream on a valid/ready stream.
//   clk100, reset        : clock, asynchronous active-low reset
//   arm, abort           : start-of-run request, run termination
//   num_data_pts         : shots per run (sampled on accepted arm)
//   timeout_cycles       : trigger_out -> iq_valid limit, 0 disables
//   trigger_in/out       : external trigger in, gated trigger out
//   iq_valid, i_val/q_val: integrator result strobe and totals
//   res                  : result stream (res_valid/ready/i/q/idx)
//   busy, cfg_lock       : run in progress
//   done, aborted        : end-of-run pulses
//   err_drop, err_timeout: sticky error flags
//   sum_i, sum_q         : run accumulators
// Build option: SHOT_SEQ_ACCUM_EN enables the accumulators.
module shot_sequencer
    import shot_seq_pkg::*;
#(
    parameter int SHOT_W = SHOT_W_DEF,
    parameter int TO_W   = TO_W_DEF
) (
    input  logic                     clk100,
    input  logic                     reset,
    input  logic                     arm,
    input  logic                     abort,
    input  logic [SHOT_W-1:0]        num_data_pts,
    input  logic [TO_W-1:0]          timeout_cycles,
    input  logic                     trigger_in,
    output logic                     trigger_out,
    input  logic                     iq_valid,
    input  logic signed [DATA_W-1:0] i_val,
    input  logic signed [DATA_W-1:0] q_val,
    shot_seq_if.master               res,
    output logic                     busy,
    output logic                     cfg_lock,
    output logic                     done,
    output logic                     aborted,
    output logic                     err_drop,
    output logic                     err_timeout,
    output logic signed [ACC_W-1:0]  sum_i,
    output logic signed [ACC_W-1:0]  sum_q
);

    shot_state_t       state;
    logic [SHOT_W-1:0] cnt_lat;
    logic [SHOT_W-1:0] shot_idx;
    logic [TO_W-1:0]   to_cnt;

    logic            abort_hit;
    logic            arm_go;
    logic            capture;
    logic            handshake;
    logic            to_hit;
    logic            drop;
    logic [TO_W:0]   to_next;

    // Abort only acts on a live run, and it also blocks a same-cycle arm.
    assign abort_hit = abort && (state != IDLE);
    assign arm_go    = (state == IDLE) && arm && !abort && (num_data_pts != '0);
    assign capture   = (state == ACQ) && iq_valid && !abort;
    assign handshake = (state == HOLD) && res.res_valid && res.res_ready;

    // One bit wider so a counter at its maximum cannot wrap into a false match.
    assign to_next = {1'b0, to_cnt} + (TO_W+1)'(1);
    assign to_hit  = (timeout_cycles != '0) && (to_next == {1'b0, timeout_cycles});

    assign drop = (trigger_in && (state != ARMED)) || (iq_valid && (state != ACQ));

    assign cfg_lock = busy;

    // control stage -> registered state and status outputs
    always_ff @(posedge clk100 or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt_lat     <= '0;
            shot_idx    <= '0;
            to_cnt      <= '0;
            trigger_out <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            err_drop    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            trigger_out <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;

            if (abort_hit) begin
                state   <= IDLE;
                busy    <= 1'b0;
                aborted <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (arm && !abort) begin
                            err_drop    <= 1'b0;
                            err_timeout <= 1'b0;
                            if (num_data_pts != '0) begin
                                cnt_lat  <= num_data_pts;
                                shot_idx <= '0;
                                state    <= ARMED;
                                busy     <= 1'b1;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    ARMED: begin
                        if (trigger_in) begin
                            trigger_out <= 1'b1;
                            to_cnt      <= '0;
                            state       <= ACQ;
                        end
                    end
                    ACQ: begin
                        if (iq_valid) begin
                            state <= HOLD;
                        end else begin
                            to_cnt <= to_cnt + TO_W'(1);
                            if (to_hit) begin
                                err_timeout <= 1'b1;
                                aborted     <= 1'b1;
                                state       <= IDLE;
                                busy        <= 1'b0;
                            end
                        end
                    end
                    HOLD: begin
                        // Leaving HOLD only on handshake is what enforces backpressure.
                        if (handshake) begin
                            if (shot_idx == cnt_lat - SHOT_W'(1)) begin
                                done  <= 1'b1;
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                shot_idx <= shot_idx + SHOT_W'(1);
                                state    <= ARMED;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

            // Placed after the arm clear so a drop in the arm cycle is still recorded.
            if (drop)
                err_drop <= 1'b1;
        end
    end

    shot_seq_out_reg #(
        .SHOT_W (SHOT_W)
    ) u_out_reg (
        .clk100     (clk100),
        .reset      (reset),
        .load_p0    (capture),
        .clear_p0   (abort_hit),
        .acc_clr_p0 (arm_go),
        .i_p0       (i_val),
        .q_p0       (q_val),
        .idx_p0     (shot_idx),
        .res        (res),
        .sum_i      (sum_i),
        .sum_q      (sum_q)
    );

endmodule

// File: tb/tb_shot_sequencer.sv
// tb_shot_sequencer: scoreboard bench for shot_sequencer. Directed stimulus
// pushes expected results into a queue; a monitor pops and compares on every
// result handshake.
module tb_shot_sequencer;

    logic               clk100 = 1'b0;
    logic               reset;
    logic               arm, abort, trigger_in, iq_valid;
    logic [15:0]        num_data_pts, timeout_cycles;
    logic signed [31:0] i_val, q_val;
    logic               trigger_out, busy, cfg_lock, done, aborted, err_drop, err_timeout;
    logic signed [47:0] sum_i, sum_q;

    shot_seq_if #(.SHOT_W(16)) rif ();

    shot_sequencer #(.SHOT_W(16), .TO_W(16)) dut (
        .clk100         (clk100),
        .reset          (reset),
        .arm            (arm),
        .abort          (abort),
        .num_data_pts   (num_data_pts),
        .timeout_cycles (timeout_cycles),
        .trigger_in     (trigger_in),
        .trigger_out    (trigger_out),
        .iq_valid       (iq_valid),
        .i_val          (i_val),
        .q_val          (q_val),
        .res            (rif),
        .busy           (busy),
        .cfg_lock       (cfg_lock),
        .done           (done),
        .aborted        (aborted),
        .err_drop       (err_drop),
        .err_timeout    (err_timeout),
        .sum_i          (sum_i),
        .sum_q          (sum_q)
    );

    always #5 clk100 = ~clk100;

    typedef struct {
        logic signed [31:0] i;
        logic signed [31:0] q;
        logic [15:0]        idx;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   trig_cnt = 0;
    int   done_cnt = 0;
    int   abrt_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: event counters and scoreboard pops on handshake cycles.
    always @(negedge clk100) begin
        if (trigger_out) trig_cnt++;
        if (done)        done_cnt++;
        if (aborted)     abrt_cnt++;
        if (reset && rif.res_valid && rif.res_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got idx %0d with empty queue", rif.res_idx);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("res_i", rif.res_i, e.i);
                chk("res_q", rif.res_q, e.q);
                chk("res_idx", rif.res_idx, e.idx);
            end
        end
    end

    task automatic tick();
        @(posedge clk100);
        #1;
    endtask

    task automatic arm_run(input logic [15:0] n);
        num_data_pts = n;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic trig();
        trigger_in = 1'b1;
        tick();
        trigger_in = 1'b0;
    endtask

    task automatic shot(input logic signed [31:0] i, input logic signed [31:0] q,
                        input logic [15:0] idx, input bit push);
        exp_t e;
        e.i = i; e.q = q; e.idx = idx;
        if (push) sb.push_back(e);
        iq_valid = 1'b1;
        i_val = i;
        q_val = q;
        tick();
        iq_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit unstable;
        reset = 1'b0; arm = 1'b0; abort = 1'b0; trigger_in = 1'b0; iq_valid = 1'b0;
        num_data_pts = '0; timeout_cycles = '0; i_val = '0; q_val = '0;
        rif.res_ready = 1'b0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_cfg_lock", cfg_lock, 0);
        chk("rst_done", done, 0);
        chk("rst_trigger_out", trigger_out, 0);
        chk("rst_res_valid", rif.res_valid, 0);
        chk("rst_res_i", rif.res_i, 0);
        chk("rst_err_drop", err_drop, 0);
        chk("rst_err_timeout", err_timeout, 0);
        chk("rst_sum_i", sum_i, 0);
        reset = 1'b1;
        tick();

        // Nominal three-shot run
        rif.res_ready = 1'b1;
        arm_run(16'd3);
        chk("nom_busy", busy, 1);
        chk("nom_cfg_lock", cfg_lock, 1);
        for (int k = 0; k < 3; k++) begin
            trig();
            chk("nom_trigger_out", trigger_out, 1);
            shot(32'sd10 * k, -k, 16'(k), 1'b1);
            chk("nom_res_valid", rif.res_valid, 1);
            tick();
            if (k < 2) chk("nom_busy_mid", busy, 1);
            else begin
                chk("nom_done", done, 1);
                chk("nom_busy_end", busy, 0);
            end
        end
        tick();
        chk("nom_done_clear", done, 0);
        chk("nom_done_cnt", done_cnt, 1);
        chk("nom_trig_cnt", trig_cnt, 3);
`ifdef SHOT_SEQ_ACCUM_EN
        chk("nom_sum_i", sum_i, 48'sd30);
        chk("nom_sum_q", sum_q, -48'sd3);
`else
        chk("nom_sum_i", sum_i, 48'sd0);
        chk("nom_sum_q", sum_q, 48'sd0);
`endif

        // Backpressure with a dropped trigger during the stall
        rif.res_ready = 1'b0;
        arm_run(16'd2);
        trig();
        shot(32'sd111, -32'sd222, 16'd0, 1'b1);
        chk("bp_res_valid", rif.res_valid, 1);
        base = trig_cnt;
        unstable = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (c == 5) trigger_in = 1'b1;
            tick();
            trigger_in = 1'b0;
            if (rif.res_i !== 32'sd111 || rif.res_valid !== 1'b1) unstable = 1'b1;
        end
        chk("bp_stable", unstable, 0);
        chk("bp_no_trigger", trig_cnt, base);
        chk("bp_err_drop", err_drop, 1);
        rif.res_ready = 1'b1;
        tick();
        trig();
        chk("bp_trigger_after", trigger_out, 1);
        shot(32'sd5, 32'sd7, 16'd1, 1'b1);
        tick();
        chk("bp_done", done, 1);
        tick();

        // Timeout
        timeout_cycles = 16'd5;
        base = done_cnt;
        arm_run(16'd4);
        trig();
        chk("to_trigger_out", trigger_out, 1);
        repeat (4) tick();
        chk("to_err_early", err_timeout, 0);
        chk("to_busy_early", busy, 1);
        tick();
        chk("to_err_timeout", err_timeout, 1);
        chk("to_aborted", aborted, 1);
        chk("to_busy", busy, 0);
        tick();
        chk("to_aborted_clear", aborted, 0);
        chk("to_no_done", done_cnt, base);

        // Abort beats iq_valid, then a clean run
        timeout_cycles = 16'd0;
        arm_run(16'd2);
        chk("ab_err_cleared", err_timeout, 0);
        trig();
        abort = 1'b1; iq_valid = 1'b1; i_val = 32'sd99; q_val = 32'sd98;
        tick();
        abort = 1'b0; iq_valid = 1'b0;
        chk("ab_res_valid", rif.res_valid, 0);
        chk("ab_aborted", aborted, 1);
        chk("ab_busy", busy, 0);
        trig();
        chk("ab_idle_drop", err_drop, 1);
        arm_run(16'd1);
        chk("ab_rearm_drop_clear", err_drop, 0);
        trig();
        shot(-32'sd7, 32'sd9, 16'd0, 1'b1);
        tick();
        chk("ab_done", done, 1);
        tick();

        // Zero-count run
        base = trig_cnt;
        arm_run(16'd0);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        tick();
        chk("zero_done_clear", done, 0);
        chk("zero_busy_after", busy, 0);
        chk("zero_no_trigger", trig_cnt, base);

        // Asynchronous reset while holding a result
        rif.res_ready = 1'b0;
        arm_run(16'd2);
        trig();
        shot(32'sd42, 32'sd43, 16'd0, 1'b0);
        chk("ar_res_valid_pre", rif.res_valid, 1);
        #2 reset = 1'b0;
        #1;
        chk("ar_res_valid", rif.res_valid, 0);
        chk("ar_res_i", rif.res_i, 0);
        chk("ar_busy", busy, 0);
        chk("ar_cfg_lock", cfg_lock, 0);
        tick();
        reset = 1'b1;
        tick();
        chk("ar_busy_after", busy, 0);
        chk("ar_res_valid_after", rif.res_valid, 0);
        rif.res_ready = 1'b1;
        tick();
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
